// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//  Shared definitions for the ALU and the divide sequencer that borrows it:
//  ALU opcode constants, the RV32M divide-operation encoding and the
//  sequencer state encoding.
// -----------------------------------------------------------------------------
package alu_pkg;

   // ALU opcodes used by the sequencer
   localparam logic [3:0] OP_ADD  = 4'b0000;  // driven while the ALU is not owned
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SLTU = 4'b0011;

   // RV32M divide flavours, as presented on i_div_op
   typedef enum logic [1:0] {
      DIVOP_DIV  = 2'b00,
      DIVOP_DIVU = 2'b01,
      DIVOP_REM  = 2'b10,
      DIVOP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ABS_A = 3'd1,
      S_ABS_B = 3'd2,
      S_CMP   = 3'd3,
      S_SUB   = 3'd4,
      S_FIX   = 3'd5,
      S_DONE  = 3'd6
   } divseq_state_e;

   // DIV and REM are the signed flavours (bit 0 clear)
   function automatic logic is_signed_op(input div_op_e op);
      return ~op[0];
   endfunction

   // REM and REMU return the remainder (bit 1 set)
   function automatic logic is_rem_op(input div_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/alu_div_sequencer.sv
// -----------------------------------------------------------------------------
// alu_div_sequencer
//  Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer. It takes over the shared
//  execute-stage ALU (o_alu_own=1) and runs a restoring divide on magnitudes:
//    IDLE -> ABS_A -> ABS_B -> {CMP,SUB} x32 -> FIX -> DONE -> IDLE
//  Result appears 67 cycles after the accept edge and is held until consumed.
//
// Ports
//  i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//  i_start / o_ready     request handshake, accepted when both are high
//  i_div_op              00 DIV, 01 DIVU, 10 REM, 11 REMU
//  i_dividend, i_divisor operands, sampled on accept
//  i_kill                synchronous abort, beats i_start in the same cycle
//  o_alu_own             sequencer drives the ALU this cycle
//  o_alu_operand_a/_b    ALU operand drives
//  o_alu_op              ALU opcode drive
//  i_alu_data            combinational ALU result
//  o_valid / i_res_ready result handshake, o_result held while o_valid
//  o_result              quotient or remainder
//
// Configuration
//  DIVSEQ_FAST_ZERO_EN   when defined, a zero divisor skips the iteration:
//                        ABS_A -> FIX -> DONE without owning the ALU, so
//                        o_valid rises 2 cycles after accept. Results match
//                        the full path.
// -----------------------------------------------------------------------------
module alu_div_sequencer
   import alu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   output logic        o_ready,
   input  logic [1:0]  i_div_op,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   input  logic        i_kill,
   output logic        o_alu_own,
   output logic [31:0] o_alu_operand_a,
   output logic [31:0] o_alu_operand_b,
   output logic [3:0]  o_alu_op,
   input  logic [31:0] i_alu_data,
   output logic        o_valid,
   input  logic        i_res_ready,
   output logic [31:0] o_result
);

   divseq_state_e state_q, state_d;

   logic [31:0] q_q;          // dividend magnitude, shifted out as quotient bits shift in
   logic [31:0] r_q;          // partial remainder
   logic [31:0] d_q;          // divisor magnitude
   logic [4:0]  cnt_q;        // iteration counter, one count per SUB cycle
   logic        take_q;       // CMP decision consumed by the following SUB
   logic        neg_a_q;      // signed op with negative dividend (also remainder sign)
   logic        neg_b_q;      // signed op with negative divisor
   logic        neg_quot_q;   // quotient must be negated
   logic        is_rem_q;
   logic [31:0] result_q;

`ifdef DIVSEQ_FAST_ZERO_EN
   logic        zero_q;       // divisor was zero at accept: bypass the ALU entirely
`endif

   logic        accept;
   logic        sgn_in;
   logic [31:0] rs;           // shifted remainder {R[30:0], Q[31]}
   logic        carry;        // bit shifted out of R; Rs >= 2^32 forces a take
   logic [31:0] fix_sel;
   logic        fix_neg;
   logic [31:0] fix_result;

   assign accept  = i_start && (state_q == S_IDLE) && !i_kill;
   assign sgn_in  = is_signed_op(div_op_e'(i_div_op));
   assign rs      = {r_q[30:0], q_q[31]};
   assign carry   = r_q[31];
   assign fix_sel = is_rem_q ? r_q : q_q;
   assign fix_neg = is_rem_q ? neg_a_q : neg_quot_q;

   always_comb begin
      fix_result = fix_neg ? i_alu_data : fix_sel;
`ifdef DIVSEQ_FAST_ZERO_EN
      // Divide by zero: quotient all ones, remainder is the untouched dividend
      if (zero_q) fix_result = is_rem_q ? q_q : 32'hFFFF_FFFF;
`endif
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
   // pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: the default assignment at the top of each always_comb keeps every
   // path assigned, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_ABS_A;
         S_ABS_A: begin
            state_d = S_ABS_B;
`ifdef DIVSEQ_FAST_ZERO_EN
            if (zero_q) state_d = S_FIX;
`endif
         end
         S_ABS_B: state_d = S_CMP;
         S_CMP:   state_d = S_SUB;
         S_SUB:   state_d = (cnt_q == 5'd31) ? S_FIX : S_CMP;
         S_FIX:   state_d = S_DONE;
         S_DONE:  if (i_res_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (i_kill) state_d = S_IDLE;
   end

   // ---------------------------------------------------------------------------
   // Output logic: ALU drives and handshakes
   // ---------------------------------------------------------------------------
   always_comb begin
      o_alu_own       = 1'b0;
      o_alu_operand_a = '0;
      o_alu_operand_b = '0;
      o_alu_op        = OP_ADD;
      unique case (state_q)
         S_ABS_A: begin
            o_alu_own       = 1'b1;
            o_alu_operand_b = q_q;     // 0 - dividend
            o_alu_op        = OP_SUB;
         end
         S_ABS_B: begin
            o_alu_own       = 1'b1;
            o_alu_operand_b = d_q;     // 0 - divisor
            o_alu_op        = OP_SUB;
         end
         S_CMP: begin
            o_alu_own       = 1'b1;
            o_alu_operand_a = rs;
            o_alu_operand_b = d_q;
            o_alu_op        = OP_SLTU;
         end
         S_SUB: begin
            o_alu_own       = 1'b1;
            o_alu_operand_a = rs;
            o_alu_operand_b = d_q;
            o_alu_op        = OP_SUB;
         end
         S_FIX: begin
            o_alu_own       = 1'b1;
            o_alu_operand_b = fix_sel; // 0 - selected result
            o_alu_op        = OP_SUB;
         end
         default: ;
      endcase
`ifdef DIVSEQ_FAST_ZERO_EN
      if (zero_q && (state_q == S_ABS_A || state_q == S_FIX)) begin
         o_alu_own       = 1'b0;
         o_alu_operand_a = '0;
         o_alu_operand_b = '0;
         o_alu_op        = OP_ADD;
      end
`endif
   end

   assign o_ready  = (state_q == S_IDLE);
   assign o_valid  = (state_q == S_DONE);
   assign o_result = result_q;

   // ---------------------------------------------------------------------------
   // Datapath: operands are captured only on accept, so a start while busy
   // cannot disturb them. After a kill the registers may hold stale values;
   // the next accept reloads everything that matters.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         q_q        <= '0;
         r_q        <= '0;
         d_q        <= '0;
         cnt_q      <= '0;
         take_q     <= 1'b0;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         neg_quot_q <= 1'b0;
         is_rem_q   <= 1'b0;
         result_q   <= '0;
`ifdef DIVSEQ_FAST_ZERO_EN
         zero_q     <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  q_q        <= i_dividend;
                  r_q        <= '0;
                  d_q        <= i_divisor;
                  cnt_q      <= '0;
                  neg_a_q    <= sgn_in & i_dividend[31];
                  neg_b_q    <= sgn_in & i_divisor[31];
                  // Divide by zero keeps the all-ones quotient un-negated
                  neg_quot_q <= sgn_in & (i_dividend[31] ^ i_divisor[31])
                                & (i_divisor != 32'd0);
                  is_rem_q   <= is_rem_op(div_op_e'(i_div_op));
`ifdef DIVSEQ_FAST_ZERO_EN
                  zero_q     <= (i_divisor == 32'd0);
`endif
               end
            end
            S_ABS_A: begin
`ifdef DIVSEQ_FAST_ZERO_EN
               if (neg_a_q && !zero_q) q_q <= i_alu_data;
`else
               if (neg_a_q) q_q <= i_alu_data;
`endif
            end
            S_ABS_B: if (neg_b_q) d_q <= i_alu_data;
            S_CMP:   take_q <= carry | ~i_alu_data[0];
            S_SUB: begin
               q_q   <= {q_q[30:0], take_q};
               r_q   <= take_q ? i_alu_data : rs;
               cnt_q <= cnt_q + 5'd1;
            end
            S_FIX:   result_q <= fix_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_div_sequencer
//  Self-checking bench: a behavioural ALU answers the sequencer's requests,
//  a vector table plus random operands drive full divide operations, and a
//  scoreboard queue holds the expected result until o_valid. Hand-written
//  sequences cover result back-pressure, mid-operation reset and kill.
// -----------------------------------------------------------------------------
module tb_alu_div_sequencer;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic        o_ready;
   logic [1:0]  i_div_op;
   logic [31:0] i_dividend;
   logic [31:0] i_divisor;
   logic        i_kill;
   logic        o_alu_own;
   logic [31:0] o_alu_operand_a;
   logic [31:0] o_alu_operand_b;
   logic [3:0]  o_alu_op;
   logic [31:0] alu_data;
   logic        o_valid;
   logic        i_res_ready;
   logic [31:0] o_result;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] sb_q[$];

   alu_div_sequencer dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_start         (i_start),
      .o_ready         (o_ready),
      .i_div_op        (i_div_op),
      .i_dividend      (i_dividend),
      .i_divisor       (i_divisor),
      .i_kill          (i_kill),
      .o_alu_own       (o_alu_own),
      .o_alu_operand_a (o_alu_operand_a),
      .o_alu_operand_b (o_alu_operand_b),
      .o_alu_op        (o_alu_op),
      .i_alu_data      (alu_data),
      .o_valid         (o_valid),
      .i_res_ready     (i_res_ready),
      .o_result        (o_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural shared ALU
   always_comb begin
      alu_data = '0;
      case (o_alu_op)
         OP_ADD:  alu_data = o_alu_operand_a + o_alu_operand_b;
         OP_SUB:  alu_data = o_alu_operand_a - o_alu_operand_b;
         OP_SLTU: alu_data = {31'd0, (o_alu_operand_a < o_alu_operand_b)};
         default: alu_data = '0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // RV32M reference semantics
   function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      if (b == 32'd0) begin
         r = op[1] ? a : 32'hFFFF_FFFF;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = op[1] ? 32'd0 : 32'h8000_0000;
      end else begin
         case (op)
            2'b00:   r = $signed(a) / $signed(b);
            2'b01:   r = a / b;
            2'b10:   r = $signed(a) % $signed(b);
            default: r = a % b;
         endcase
      end
      return r;
   endfunction

   // Drive one operation, check latency, ALU ownership and result, then consume it
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
      int   lat;
      int   exp_lat;
      int   own_bad;
      logic exp_own;
      exp_lat = 67;
      exp_own = 1'b1;
`ifdef DIVSEQ_FAST_ZERO_EN
      if (b == 32'd0) begin
         exp_lat = 2;
         exp_own = 1'b0;
      end
`endif
      i_div_op   = op;
      i_dividend = a;
      i_divisor  = b;
      i_start    = 1'b1;
      sb_q.push_back(exp);
      @(negedge clk);
      i_start    = 1'b0;
      // Scramble inputs to show the sampled operands are frozen
      i_dividend = $urandom;
      i_divisor  = $urandom;
      check({name, " ready_low"}, {31'd0, o_ready}, 32'd0);
      lat     = 0;
      own_bad = 0;
      while (!o_valid && lat < 200) begin
         if (o_alu_own !== exp_own) own_bad++;
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, lat, exp_lat);
      check({name, " alu_own"}, own_bad, 32'd0);
      check({name, " result"}, o_result, sb_q.pop_front());
      if (!o_valid) begin
         i_kill = 1'b1;
         @(negedge clk);
         i_kill = 1'b0;
      end
      i_res_ready = 1'b1;
      @(negedge clk);
      i_res_ready = 1'b0;
      check({name, " ready_after"}, {31'd0, o_ready}, 32'd1);
   endtask

   // Watch for a spurious o_valid over a number of cycles
   task automatic expect_quiet(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int k = 0; k < cycles; k++) begin
         if (o_valid) seen++;
         @(negedge clk);
      end
      check({name, " no_valid"}, seen, 32'd0);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
      vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
      vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
      vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
      vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
      vecs[5]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
      vecs[6]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
      vecs[7]  = '{2'b10, 32'd5,          32'd0,          32'd5};
      vecs[8]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
      vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
      vecs[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
      vecs[11] = '{2'b01, 32'd9,          32'd0,          32'hFFFF_FFFF};
      vecs[12] = '{2'b11, 32'd9,          32'd0,          32'd9};
      vecs[13] = '{2'b00, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF};
      vecs[14] = '{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9};
      vecs[15] = '{2'b01, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA};

      rst_n       = 1'b0;
      i_start     = 1'b0;
      i_div_op    = 2'b00;
      i_dividend  = '0;
      i_divisor   = '0;
      i_kill      = 1'b0;
      i_res_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst ready",  {31'd0, o_ready},   32'd1);
      check("rst valid",  {31'd0, o_valid},   32'd0);
      check("rst own",    {31'd0, o_alu_own}, 32'd0);
      check("rst result", o_result,           32'd0);
      check("rst alu_a",  o_alu_operand_a,    32'd0);
      check("rst alu_b",  o_alu_operand_b,    32'd0);
      check("rst alu_op", {28'd0, o_alu_op},  {28'd0, OP_ADD});
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors
      for (int i = 0; i < 16; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

      // Random operands against the reference model
      for (int i = 0; i < 8; i++) begin
         logic [1:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (i == 7) b = ~b + 32'd1 | 32'h8000_0000;   // force a negative divisor
         run_op(op, a, b, ref_model(op, a, b), $sformatf("rnd%0d", i));
      end

      // Back-pressure: result held, second start ignored
      begin
         int lat;
         int bad_valid;
         int bad_result;
         i_div_op   = 2'b01;
         i_dividend = 32'd1000;
         i_divisor  = 32'd10;
         i_start    = 1'b1;
         @(negedge clk);
         i_start = 1'b0;
         lat = 0;
         while (!o_valid && lat < 200) begin
            @(negedge clk);
            lat++;
         end
         check("hold latency", lat, 32'd67);
         bad_valid  = 0;
         bad_result = 0;
         for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
               i_start    = 1'b1;
               i_dividend = 32'd77;
               i_divisor  = 32'd1;
            end else begin
               i_start = 1'b0;
            end
            if (o_valid !== 1'b1) bad_valid++;
            if (o_result !== 32'd100) bad_result++;
            @(negedge clk);
         end
         i_start = 1'b0;
         check("hold valid",  bad_valid,  32'd0);
         check("hold result", bad_result, 32'd0);
         check("hold result_end", o_result, 32'd100);
         i_res_ready = 1'b1;
         @(negedge clk);
         i_res_ready = 1'b0;
         check("hold ready_after", {31'd0, o_ready}, 32'd1);
         expect_quiet("hold", 80);
      end

      // Asynchronous reset in the middle of the iteration
      i_div_op   = 2'b01;
      i_dividend = 32'hFFFF_FFFF;
      i_divisor  = 32'd3;
      i_start    = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (22) @(negedge clk);
      check("mid own_busy", {31'd0, o_alu_own}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst ready",  {31'd0, o_ready},   32'd1);
      check("mid_rst valid",  {31'd0, o_valid},   32'd0);
      check("mid_rst own",    {31'd0, o_alu_own}, 32'd0);
      check("mid_rst result", o_result,           32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_quiet("mid_rst", 80);

      // Kill in the middle of the iteration
      i_div_op   = 2'b00;
      i_dividend = 32'hFFFF_FF9C;   // -100
      i_divisor  = 32'd7;
      i_start    = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (32) @(negedge clk);
      i_kill = 1'b1;
      @(negedge clk);
      i_kill = 1'b0;
      check("kill ready", {31'd0, o_ready},   32'd1);
      check("kill own",   {31'd0, o_alu_own}, 32'd0);
      expect_quiet("kill", 80);
      check("kill result", o_result, 32'd0);

      // Kill beats start in the same cycle
      i_start = 1'b1;
      i_kill  = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      i_kill  = 1'b0;
      check("kill_start ready", {31'd0, o_ready},   32'd1);
      check("kill_start own",   {31'd0, o_alu_own}, 32'd0);

      // Normal operation after the aborts
      run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, "post_div");
      run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, "post_rem");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
